fifo_wr_ctrl: RTL

Write-side controller for the async FIFO. It runs entirely in the write clock domain and sits directly upstream of the dual-port RAM, feeding it the write address and the full flag.
- Keeps the binary and Gray write pointers.
- Synchronizes the read-domain Gray pointer through a 2-flop synchronizer.
- Generates registered full, almost-full, fill-level and overflow indications.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_wr_ctrl_if.sv | 32 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/fifo_wr_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Gray/binary pointer conversions shared by both FIFO controllers.
// Revision    : 1.0
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_GRAY_W = 32;

    typedef logic [c_GRAY_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down; zero-extended inputs convert correctly.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[c_GRAY_W-1] = gray[c_GRAY_W-1];
        for (int i = c_GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl_if
// Description : Push/status bundle between a producer and the FIFO write side.
// Revision    : 1.0
// ============================================================================
interface fifo_wr_ctrl_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 i_wr_en;
    logic [PTR_WIDTH:0]   i_rd_gray_ptr;
    logic [PTR_WIDTH-1:0] o_wr_ptr;
    logic [PTR_WIDTH:0]   o_wr_gray_ptr;
    logic                 o_wr_accept;
    logic                 o_wr_full;
    logic                 o_wr_almost_full;
    logic [PTR_WIDTH:0]   o_wr_level;
    logic                 o_wr_overflow;

    modport master (
        output i_wr_en, i_rd_gray_ptr,
        input  o_wr_ptr, o_wr_gray_ptr, o_wr_accept, o_wr_full,
               o_wr_almost_full, o_wr_level, o_wr_overflow
    );

    modport slave (
        input  i_wr_en, i_rd_gray_ptr,
        output o_wr_ptr, o_wr_gray_ptr, o_wr_accept, o_wr_full,
               o_wr_almost_full, o_wr_level, o_wr_overflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Plain two-flop synchronizer for a Gray-coded bus.
// Revision    : 1.0
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;
endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Async FIFO write-side pointer, full/level and overflow logic.
// Revision    : 1.0
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PTR_WIDTH   = $clog2(DEPTH),
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  wire logic     clk_wr,
    input  wire logic     rst,
    fifo_wr_ctrl_if.slave bus
);
    localparam int                 c_PW    = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] c_AFULL = c_PW'(AFULL_LEVEL);

    logic [PTR_WIDTH:0] r_wr_bin;
    logic [PTR_WIDTH:0] r_wr_gray;
    logic [PTR_WIDTH:0] r_level;
    logic               r_full;
    logic               r_afull;
    logic               r_overflow;

    logic               w_accept;
    logic [PTR_WIDTH:0] w_bin_next;
    logic [PTR_WIDTH:0] w_gray_next;
    logic [PTR_WIDTH:0] w_rq2;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_full_cmp;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_full_next;
    logic               w_afull_next;

    sync_2ff #(
        .WIDTH (c_PW)
    ) u_rd_sync (
        .clk (clk_wr),
        .rst (rst),
        .i_d (bus.i_rd_gray_ptr),
        .o_q (w_rq2)
    );

    // Acceptance looks only at the registered flag, so a read that frees a
    // slot in this same cycle cannot rescue a push made while full.
    assign w_accept     = bus.i_wr_en & ~r_full;
    assign w_bin_next   = r_wr_bin + {{PTR_WIDTH{1'b0}}, w_accept};
    assign w_gray_next  = c_PW'(bin2gray(c_GRAY_W'(w_bin_next)));
    assign w_rbin       = c_PW'(gray2bin(c_GRAY_W'(w_rq2)));
    assign w_full_cmp   = {~w_rq2[PTR_WIDTH:PTR_WIDTH-1], w_rq2[PTR_WIDTH-2:0]};
    assign w_full_next  = (w_gray_next == w_full_cmp);
    assign w_level_next = w_bin_next - w_rbin;
    assign w_afull_next = (w_level_next >= c_AFULL);

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_bin   <= w_bin_next;
            r_wr_gray  <= w_gray_next;
            r_level    <= w_level_next;
            r_full     <= w_full_next;
            r_afull    <= w_afull_next;
            r_overflow <= bus.i_wr_en & r_full;
        end
    end

    assign bus.o_wr_ptr         = r_wr_bin[PTR_WIDTH-1:0];
    assign bus.o_wr_gray_ptr    = r_wr_gray;
    assign bus.o_wr_accept      = w_accept;
    assign bus.o_wr_full        = r_full;
    assign bus.o_wr_almost_full = r_afull;
    assign bus.o_wr_level       = r_level;
    assign bus.o_wr_overflow    = r_overflow;
endmodule
`default_nettype wire
